// File: rtl/sobel_stream.sv
// sobel_stream: raster RGB stream -> grayscale -> 3x3 Sobel |Gx|+|Gy| edge value.
// Latency: 3 cycles (gray reg, window/line-buffer reg, gradient/output reg); gaps preserved.
// Backpressure: none; a pixel is accepted on every cycle in_valid is high.
//
// Ports: clk, reset (async active-low); in_valid/in_sof/in_pix[23:0] raster RGB input;
//        out_valid/out_sof/out_pix[23:0] edge value m as {m,m,m}, delayed by 3 cycles.
// Build option: define SOBEL_THRESHOLD_EN to binarise the edge map against THRESH.
module sobel_stream #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int THRESH = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [23:0] in_pix,
  output logic        out_valid,
  output logic        out_sof,
  output logic [23:0] out_pix
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // ---------------- stage 0: position tracking and gray conversion
  logic          sof_acc;
  logic [CW-1:0] cur_col, col_q, col_d;
  logic [RW-1:0] cur_row, row_q, row_d;
  logic [9:0]    gray_sum;

  // An accepted SOF pins this pixel to (0,0) regardless of the running counters.
  assign sof_acc  = in_valid & in_sof;
  assign cur_col  = sof_acc ? '0 : col_q;
  assign cur_row  = sof_acc ? '0 : row_q;
  assign gray_sum = {2'b00, in_pix[23:16]} + {1'b0, in_pix[15:8], 1'b0} + {2'b00, in_pix[7:0]};

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  // ---------------- pipeline registers
  logic          s1_vld_q, s1_sof_q, s2_vld_q, s2_sof_q;
  logic [7:0]    s1_gray_q;
  logic [CW-1:0] s1_col_q, s2_col_q;
  logic [RW-1:0] s1_row_q, s2_row_q;
  logic [7:0]    lb0_q [IMG_W];  // one line above, indexed by column
  logic [7:0]    lb1_q [IMG_W];  // two lines above
  logic [7:0]    win_q [3][3];   // win_q[row][col], [0][0] oldest, [2][2] newest

  // Control state: reset clears positions and every valid/sof bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q    <= '0;
      row_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_sof_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_sof_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      s1_vld_q <= in_valid;
      s1_sof_q <= sof_acc;
      s2_vld_q <= s1_vld_q;
      s2_sof_q <= s1_sof_q;
    end
  end

  // Datapath state is deliberately not reset; the border mask hides stale content.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_gray_q <= gray_sum[9:2];
      s1_col_q  <= cur_col;
      s1_row_q  <= cur_row;
    end
    if (s1_vld_q) begin
      // Read-before-write on the same column: old lb0 moves down into lb1.
      lb0_q[s1_col_q] <= s1_gray_q;
      lb1_q[s1_col_q] <= lb0_q[s1_col_q];
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2] <= lb1_q[s1_col_q];
      win_q[1][2] <= lb0_q[s1_col_q];
      win_q[2][2] <= s1_gray_q;
      s2_col_q    <= s1_col_q;
      s2_row_q    <= s1_row_q;
    end
  end

  // ---------------- stage 3: gradients, magnitude, mask
  logic [9:0]  gx_p, gx_n, gy_p, gy_n, gx_abs, gy_abs;
  logic [11:0] mag;
  logic [7:0]  m_val, m_out;
  logic        border;

  assign gx_p = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
  assign gx_n = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
  assign gy_p = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
  assign gy_n = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};

  // |a-b| taken directly on the unsigned halves; identical to abs of the signed gradient.
  assign gx_abs = (gx_p >= gx_n) ? gx_p - gx_n : gx_n - gx_p;
  assign gy_abs = (gy_p >= gy_n) ? gy_p - gy_n : gy_n - gy_p;
  assign mag    = {2'b00, gx_abs} + {2'b00, gy_abs};

`ifdef SOBEL_THRESHOLD_EN
  localparam logic [11:0] THRESH_C = 12'(THRESH);
  assign m_val = (mag >= THRESH_C) ? 8'hFF : 8'h00;
`else
  assign m_val = (mag > 12'd255) ? 8'hFF : mag[7:0];
`endif

  // Window is centred one line and one pixel behind the newest pixel; the
  // first two rows/cols of the stream hold wrapped or stale neighbours.
  assign border = (s2_row_q < RW'(2)) || (s2_col_q < CW'(2));
  assign m_out  = border ? 8'h00 : m_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_pix   <= 24'h0;
    end else begin
      out_valid <= s2_vld_q;
      out_sof   <= s2_sof_q;
      if (s2_vld_q) begin
        out_pix <= {m_out, m_out, m_out};
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam logic [6:0] GAP_PAT = 7'b1011001; // LSB first: 1,0,0,1,1,0,1

  typedef struct {
    logic [23:0] pix;
    logic        sof;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [23:0] in_pix = 24'h0;
  logic        out_valid, out_sof;
  logic [23:0] out_pix;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [23:0] last_pix = 24'h0;
  logic [2:0]  vh;

  sobel_stream #(.IMG_W(W), .IMG_H(H), .THRESH(128)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .out_valid(out_valid), .out_sof(out_sof), .out_pix(out_pix)
  );

  always #5 clk = ~clk;

  // ---------------- reference image model
  function automatic logic [23:0] pix_of(input int pat, input int r, input int c);
    logic [7:0] v;
    if (r < 0) r = 0;
    case (pat)
      0:       return 24'h808080;
      1:       return (c < 4) ? 24'h000000 : 24'hFFFFFF;
      default: begin v = 8'(10 * c); return {v, v, v}; end
    endcase
  endfunction

  function automatic int gray_of(input logic [23:0] p);
    return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) >> 2;
  endfunction

  function automatic logic [23:0] exp_of(input int pat, input int r, input int c);
    int w[3][3];
    int gx, gy, mag, m;
    if (r < 2 || c < 2) return 24'h0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = gray_of(pix_of(pat, r - 2 + i, c - 2 + j));
    gx = (w[0][2] + 2 * w[1][2] + w[2][2]) - (w[0][0] + 2 * w[1][0] + w[2][0]);
    gy = (w[2][0] + 2 * w[2][1] + w[2][2]) - (w[0][0] + 2 * w[0][1] + w[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
    m = (mag >= 128) ? 255 : 0;
`else
    m = (mag > 255) ? 255 : mag;
`endif
    return {3{8'(m)}};
  endfunction

  // ---------------- expected out_valid: in_valid three cycles back, cleared by reset
  always @(posedge clk or negedge reset) begin
    if (!reset) vh <= 3'b000;
    else        vh <= {vh[1:0], in_valid};
  end

  // ---------------- monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    checks++;
    assert (out_valid === vh[2]) else begin
      errors++; $error("FAIL out_valid got %0b exp %0b", out_valid, vh[2]);
    end
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb_underflow got output %h exp none", out_pix);
      end else begin
        e = sb.pop_front();
        checks++;
        assert (out_pix === e.pix) else begin
          errors++; $error("FAIL out_pix got %h exp %h", out_pix, e.pix);
        end
        checks++;
        assert (out_sof === e.sof) else begin
          errors++; $error("FAIL out_sof got %0b exp %0b", out_sof, e.sof);
        end
        last_pix = e.pix;
      end
    end else begin
      checks++;
      assert (out_sof === 1'b0) else begin
        errors++; $error("FAIL idle_sof got %0b exp 0", out_sof);
      end
      checks++;
      assert (out_pix === last_pix) else begin
        errors++; $error("FAIL hold_pix got %h exp %h", out_pix, last_pix);
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic send(input int pat, input int r, input int c, input logic sof);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sof   = sof;
    in_pix   = pix_of(pat, r, c);
    e.pix = exp_of(pat, r, c);
    e.sof = sof;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(0, 1));  // SOF without valid must be ignored
      in_pix   = 24'($urandom);
    end
  endtask

  task automatic run_frame(input int pat, input bit sof_first, input bit gapped, input int npix);
    int gi = 0;
    for (int i = 0; i < npix; i++) begin
      if (gapped) begin
        while (GAP_PAT[gi] == 1'b0) begin
          idle(1);
          gi = (gi + 1) % 7;
        end
        gi = (gi + 1) % 7;
      end
      send(pat, i / W, i % W, sof_first && (i == 0));
    end
  endtask

  // ---------------- directed sequence
  initial begin
    #2 reset = 1'b0;
    #1;
    checks++;
    assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_valid got %0b exp 0", out_valid); end
    checks++;
    assert (out_sof === 1'b0) else begin errors++; $error("FAIL rst_sof got %0b exp 0", out_sof); end
    checks++;
    assert (out_pix === 24'h0) else begin errors++; $error("FAIL rst_pix got %h exp 0", out_pix); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Uniform grey frame
    run_frame(0, 1'b1, 1'b0, W * H);
    idle(2);
    // Vertical edge frame
    run_frame(1, 1'b1, 1'b0, W * H);
    // Column ramp frame, back to back
    run_frame(2, 1'b1, 1'b0, W * H);
    idle(4);
    // Vertical edge with gapped valid
    run_frame(1, 1'b1, 1'b1, W * H);
    idle(3);

    // Reset for one cycle at pixel (3,5), restart without SOF
    run_frame(1, 1'b1, 1'b0, 3 * W + 5);
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    sb.delete();
    last_pix = 24'h0;
    #3;
    checks++;
    assert (out_valid === 1'b0 && out_pix === 24'h0) else begin
      errors++; $error("FAIL mid_reset got vld %0b pix %h exp 0/0", out_valid, out_pix);
    end
    @(posedge clk); #1 reset = 1'b1;
    run_frame(1, 1'b0, 1'b0, W * H);

    // Ramp frame interrupted by SOF at (2,4), new vertical-edge frame
    run_frame(2, 1'b1, 1'b0, 2 * W + 4);
    run_frame(1, 1'b1, 1'b0, W * H);
    idle(6);

    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL sb_drain got %0d left exp 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming 3x3 Sobel edge detector. It takes a raster-order RGB pixel stream (one pixel per valid cycle), converts each pixel to grayscale, and holds two previous lines in internal line buffers to form the 3x3 window. It computes the |Gx|+|Gy| gradient magnitude in a fixed-latency pipeline. It sits between the frame source and the VGA output path, replacing the per-pixel combinational `sobel_kernel` with a parametrised, line-buffered block.

## Interface
Parameters:
- IMG_W, 640, pixels per line (>= 3); sets the line-buffer depth.
- IMG_H, 480, lines per frame (>= 3).
- THRESH, 128, binarisation threshold; used only when SOBEL_THRESHOLD_EN is defined.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_pix is a valid pixel this cycle.
- in_sof  in  1  start of frame; qualified by in_valid, marks pixel (0,0).
- in_pix  in  24  RGB pixel: R = [23:16], G = [15:8], B = [7:0].
- out_valid  out  1  out_pix is valid.
- out_sof  out  1  output at stream position (0,0).
- out_pix  out  24  edge value m replicated as {m,m,m}.

## Operation
- Grayscale: g = (R + 2G + B) >> 2, an 8-bit unsigned value with a 10-bit intermediate.
- Position counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1.
  - Both advance only on accepted pixels (in_valid=1).
  - When col reaches IMG_W-1 it wraps to 0 and row increments.
  - When row reaches IMG_H-1 and col wraps, row also wraps to 0.
- in_sof=1 with in_valid=1 forces the current pixel to (0,0); the counters continue from there. in_sof without in_valid is ignored.
- Line buffers:
  - Two IMG_W x 8-bit buffers, addressed by col and written only on valid pixels.
  - They deliver the gray values at the same column one and two lines above.
- Window:
  - A 3x3 shift register of gray values, shifted only on valid pixels.
  - Naming: w[i][j], where i=0 is the oldest row and j=0 is the oldest column.
  - w[2][2] is the current pixel.
- Gradients, each 11-bit signed, range ±1020:
  - Gx = (w02 + 2w12 + w22) - (w00 + 2w10 + w20).
  - Gy = (w20 + 2w21 + w22) - (w00 + 2w01 + w02).
- Magnitude: mag = |Gx| + |Gy|, 12-bit unsigned, max 2040. m = min(mag, 255).
- Output mapping:
  - Exactly one output is produced per accepted input.
  - The output at stream position (r,c) is the edge value of image pixel (r-1, c-1).
  - If r < 2 or c < 2, m is forced to 0 (border). The output frame is therefore shifted by one line and one pixel.
- Stale line-buffer data (after reset or a mid-frame SOF) never reaches a non-border output, because the border rule masks the first two rows and columns.

## Timing
- Latency is exactly 3 cycles, with valid and sof carried through the same pipeline:
  - Stage 1: gray conversion registered, with valid, sof, row and col.
  - Stage 2: window and line buffers updated.
  - Stage 3: Gx, Gy, mag, saturation and border mask registered into out_pix.
- Input gaps are preserved: out_valid equals in_valid delayed by 3 cycles, and out_sof equals (in_valid & in_sof) delayed by 3 cycles.
- No back-pressure: the block accepts a pixel every cycle it is offered.
- Reset (asynchronous assert):
  - out_valid=0, out_sof=0, out_pix=24'h0.
  - All pipeline valid bits cleared; col=0, row=0.
  - Line-buffer and window contents are not cleared.
- Reset mid-frame: in-flight pixels are dropped. The next accepted pixel is treated as (0,0), whether or not in_sof is asserted.
- SOF mid-line: counters restart at (0,0) on that pixel. Outputs already in the pipeline complete unchanged.
- out_pix holds its last value while out_valid=0.

## Configuration
- SOBEL_THRESHOLD_EN:
  - Defined: m = (mag >= THRESH) ? 255 : 0, giving a binary edge map. The border still forces 0.
  - Undefined: m = min(mag, 255), and THRESH is unused.

## Test plan
All scenarios use IMG_W=8, IMG_H=6.
- Uniform frame, in_pix=24'h808080, 48 continuous pixels with SOF on the first -> every out_pix=0. out_valid high for 48 cycles starting 3 cycles after the first in_valid. out_sof on the first output only.
- Vertical edge, columns 0-3 = 24'h000000 and columns 4-7 = 24'hFFFFFF -> out_pix=24'hFFFFFF at r>=2, c∈{4,5}; 0 everywhere else. Same result with SOBEL_THRESHOLD_EN defined.
- Column ramp, R=G=B=10c -> out_pix={80,80,80} at r>=2, c∈{2..7}. With SOBEL_THRESHOLD_EN and THRESH=128, all 0.
- in_valid pattern 1,0,0,1,1,0,1... over a full frame -> out_valid reproduces the same pattern 3 cycles later, and the output values are identical to the continuous-stream run.
- reset low for 1 cycle at pixel (3,5), then the vertical-edge frame restarted without in_sof -> outputs match the vertical-edge scenario from the first post-reset pixel; out_valid=0 while reset is low.
- in_sof at pixel (2,4), then a new vertical-edge frame -> outputs for the new frame match the vertical-edge scenario from that point, with no stale non-zero values in rows 0-1.
